do_router: RTL
==============

// Module: do_router
// PURPOSE
//  Write-side counterpart of the data-in selector. Takes 32-bit write words from the
//  core/DMA data-out bus, each tagged with a 2-bit destination select (sel_DO).
//  Buffers them in a DEPTH-entry FIFO and delivers each word to one of three sinks
//  (0=memory, 1=DMA, 2=peripheral) over per-sink valid/ready handshakes.
//  Delivery is strictly in order. Select code 2'b11 is illegal: the word is consumed
//  and discarded, and an error is flagged.
// PARAMETERS
//  DEPTH    4    FIFO entries; power of two, >=2
//  AW       2    pointer width = log2(DEPTH)
// PORTS
//  clk        in   1    rising-edge clock
//  reset      in   1    asynchronous, active-high reset
//  sel_DO     in   2    destination of DO_in: 00 sink0, 01 sink1, 10 sink2, 11 illegal
//  DO_in      in   32   write data word
//  in_valid   in   1    DO_in/sel_DO valid
//  in_ready   out  1    router can accept a word this cycle
//  out_data   out  32   head-of-FIFO data, shared by all sinks
//  out_valid  out  3    one-hot; bit k = head word targets sink k
//  out_ready  in   3    bit k = sink k accepts out_data this cycle
//  err_sel    out  1    one-cycle pulse: illegal select consumed
//  count      out  AW+1 current FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain.
//  - reset (async, active-high) clears wr_ptr, rd_ptr and count to 0, and err_sel to 0.
//  - During reset: in_ready=0, out_valid=3'b000, out_data=32'h0.
//  - in_ready goes to 1 on the first clk edge after reset deasserts.
//  - A reset mid-transfer discards all buffered words. FIFO memory contents need no reset.
//  Input side
//  - Push occurs when in_valid && in_ready && sel_DO!=2'b11.
//  - A push stores {sel_DO, DO_in} at wr_ptr; wr_ptr increments mod DEPTH (wraps).
//  - in_ready = !full (count!=DEPTH), registered/flag-based. There is no combinational
//    path from out_ready to in_ready.
//  - Illegal select: when in_valid && in_ready && sel_DO==2'b11, the word is accepted
//    but not stored. err_sel=1 on the next cycle only; count is unchanged.
//  Output side
//  - When count==0: out_valid=3'b000 and out_data=32'h0.
//  - When count>0: out_data = mem[rd_ptr].data, and out_valid = one-hot of
//    mem[rd_ptr].sel (00->001, 01->010, 10->100).
//  - Pop occurs when out_valid[k] && out_ready[k] for the selected k.
//  - out_ready bits of non-selected sinks are ignored.
//  - A pop increments rd_ptr mod DEPTH.
//  - Sinks may hold ready low indefinitely. The head word and out_valid stay stable
//    until popped.
//  Latency and throughput
//  - Latency: a word pushed at edge N into an empty FIFO is visible on out_* after edge N
//    (next cycle). There is no same-cycle bypass.
//  - Throughput: 1 word/cycle sustained when the sinks are ready.
//  Simultaneous events
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//  - When full, in_ready=0, so no push occurs. A pop that cycle frees a slot, and
//    in_ready=1 from the next cycle.
//  - Empty with a push: no pop is possible that cycle, because out_valid=0.
//  - count = (#pushes - #pops), held within 0..DEPTH by the handshake rules.
// TESTING
//  1. Reset: assert reset mid-stream with 3 words queued -> count=0, out_valid=000,
//     out_data=0, in_ready=0; in_ready=1 one cycle after release.
//  2. Routing: push (00,32'hA5A5_0001), (01,32'h0000_0002), (10,32'hDEAD_BEEF) with all
//     ready=1 -> out_valid 001,010,100 on consecutive cycles, data matching, 1-cycle
//     latency.
//  3. Full/backpressure: out_ready=000, push 5 words -> 4 stored, count=4, in_ready=0;
//     set out_ready=111 -> words emerge in order, in_ready=1 after the first pop.
//  4. Wrap-around: stream 10 words with ready toggling 1010... -> all 10 delivered in
//     order; pointers wrap twice; no loss or duplication.
//  5. Illegal select: push (11,32'h1234_5678) between two legal words -> err_sel pulses
//     exactly 1 cycle, the word is never presented, count is unaffected.
//  6. Head blocking: head targets sink1 with out_ready=101 -> no pop, head held stable;
//     raise bit1 -> pop.

Source files
------------

// File: rtl/do_router.sv
// do_router: write-side router from the core/DMA data-out bus to three sinks.
// Words tagged with a 2-bit destination select are buffered in a DEPTH-entry
// FIFO and delivered strictly in order to sink 0 (memory), 1 (DMA) or
// 2 (peripheral) over per-sink valid/ready handshakes. Select 2'b11 is
// illegal: the word is consumed, dropped, and err_sel pulses for one cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   sel_DO     destination of DO_in (00/01/10 = sink 0/1/2, 11 = illegal)
//   DO_in      write data word
//   in_valid   DO_in/sel_DO valid
//   in_ready   router can accept a word this cycle (registered, never
//              combinationally dependent on out_ready)
//   out_data   head-of-FIFO data, shared by all sinks (0 when empty)
//   out_valid  one-hot, bit k = head word targets sink k (0 when empty)
//   out_ready  bit k = sink k accepts out_data this cycle
//   err_sel    one-cycle pulse after an illegal select is consumed
//   count      FIFO occupancy, 0..DEPTH
module do_router #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    sel_DO,
  input  logic [31:0]   DO_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   out_data,
  output logic [2:0]    out_valid,
  input  logic [2:0]    out_ready,
  output logic          err_sel,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Each entry holds {sel, data}.
  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;
  logic          accept;
  logic          push;
  logic          pop;
  logic          empty;
  logic [1:0]    head_sel;

  assign accept   = in_valid && in_ready;
  assign push     = accept && (sel_DO != 2'b11);
  assign empty    = (count == '0);
  assign head_sel = mem[rd_ptr][33:32];

  // Head presentation; the stored select is never 2'b11.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    if (!empty) begin
      out_data = mem[rd_ptr][31:0];
      case (head_sel)
        2'b00:   out_valid = 3'b001;
        2'b01:   out_valid = 3'b010;
        2'b10:   out_valid = 3'b100;
        default: out_valid = '0;
      endcase
    end
  end

  // Only the selected sink's ready matters since out_valid is one-hot.
  assign pop = |(out_valid & out_ready);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sel_DO, DO_in};
  end

  // in_ready is registered from the next occupancy, so a pop while full
  // re-opens the input on the following cycle without a comb path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
      err_sel  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_next;
      in_ready <= (count_next != FULL);
      err_sel  <= accept && (sel_DO == 2'b11);
    end
  end

endmodule
